// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared FSM encoding, widths and optional SOBEL_MAG_EN helper for the Sobel window controller
package sobel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int GRAD_W    = 13;
    localparam int MAG_W     = 13;
    localparam int PIX_W_DEF = 24;

`ifdef SOBEL_MAG_EN
    function automatic logic [MAG_W-1:0] grad_abs(input logic signed [GRAD_W-1:0] g);
        logic [GRAD_W-1:0] u;
        u = g[GRAD_W-1] ? -g : g;
        return u;
    endfunction
`endif

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - two-row line buffer; one write port shifts row0 into row1 at the written column
module sobel_line_buffer #(
    parameter int DEPTH = 640,
    parameter int PIX_W = 24,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [PIX_W-1:0] i_wdata,
    output logic [PIX_W-1:0] o_row0,
    output logic [PIX_W-1:0] o_row1
);

    // Each entry is {older line, newer line}; contents need no reset.
    logic [2*PIX_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= {r_mem[i_addr][PIX_W-1:0], i_wdata};
        end
    end

    assign o_row0 = r_mem[i_addr][PIX_W-1:0];
    assign o_row1 = r_mem[i_addr][2*PIX_W-1:PIX_W];

endmodule

// File: rtl/sobel_window_ctrl.sv
// rtl/sobel_window_ctrl.sv - 3x3 window builder, stall replay and output flow control for an external Sobel unit
// Defining SOBEL_MAG_EN adds the out_mag port (|Ix| + |Iy|).
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int PIX_W   = PIX_W_DEF,
    parameter int COORD_W = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PIX_W-1:0]         in_pixel,
    output logic [PIX_W-1:0]         win_x00,
    output logic [PIX_W-1:0]         win_x01,
    output logic [PIX_W-1:0]         win_x02,
    output logic [PIX_W-1:0]         win_x10,
    output logic [PIX_W-1:0]         win_x11,
    output logic [PIX_W-1:0]         win_x12,
    output logic [PIX_W-1:0]         win_x20,
    output logic [PIX_W-1:0]         win_x21,
    output logic [PIX_W-1:0]         win_x22,
    input  logic signed [GRAD_W-1:0] sob_ix,
    input  logic signed [GRAD_W-1:0] sob_iy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [GRAD_W-1:0] out_ix,
    output logic signed [GRAD_W-1:0] out_iy,
    output logic [COORD_W-1:0]       out_x,
    output logic [COORD_W-1:0]       out_y,
    output logic                     busy,
`ifdef SOBEL_MAG_EN
    output logic [MAG_W-1:0]         out_mag,
`endif
    output logic                     frame_done
);

    localparam int AW = $clog2(IMG_W);
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - 1);
    localparam logic [COORD_W-1:0] LAST_X   = COORD_W'(IMG_W - 2);
    localparam logic [COORD_W-1:0] LAST_Y   = COORD_W'(IMG_H - 2);
    localparam logic [COORD_W-1:0] TWO      = COORD_W'(2);

    state_t r_state;
    state_t w_state_nxt;

    logic [COORD_W-1:0] r_col;
    logic [COORD_W-1:0] r_row;
    logic [COORD_W-1:0] r_cx;
    logic [COORD_W-1:0] r_cy;
    logic [COORD_W-1:0] r_cx_prev;
    logic [COORD_W-1:0] r_cy_prev;
    logic [COORD_W-1:0] r_out_x;
    logic [COORD_W-1:0] r_out_y;
    logic [PIX_W-1:0]   r_win      [3][3];
    logic [PIX_W-1:0]   r_win_prev [3][3];
    logic [PIX_W-1:0]   w_sob_in   [3][3];
    logic               r_win_valid;
    logic               r_out_valid;
    logic               r_frame_done;
    logic               w_stall;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_last_pix;
    logic               w_last_out;
    logic [PIX_W-1:0]   w_lb0;
    logic [PIX_W-1:0]   w_lb1;

    assign w_stall    = r_out_valid && !out_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_last_pix = (r_col == LAST_COL) && (r_row == LAST_ROW);
    assign w_last_out = r_out_valid && out_ready && (r_out_x == LAST_X) && (r_out_y == LAST_Y);

    sobel_line_buffer #(
        .DEPTH (IMG_W),
        .PIX_W (PIX_W),
        .AW    (AW)
    ) u_line_buffer (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (r_col[AW-1:0]),
        .i_wdata (in_pixel),
        .o_row0  (w_lb0),
        .o_row1  (w_lb1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_in_ready = !w_stall;
                if (in_valid && !w_stall && w_last_pix) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_last_out) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col        <= '0;
            r_row        <= '0;
            r_cx         <= '0;
            r_cy         <= '0;
            r_cx_prev    <= '0;
            r_cy_prev    <= '0;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_win_valid  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j]      <= '0;
                    r_win_prev[i][j] <= '0;
                end
            end
        end else begin
            r_frame_done <= (r_state == ST_DRAIN) && w_last_out;

            if (r_state == ST_IDLE && start) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_accept) begin
                if (r_col == LAST_COL) begin
                    r_col <= '0;
                    r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            // New right column is rows r-2, r-1, r taken at the current column.
            if (w_accept) begin
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= w_lb1;
                r_win[1][2] <= w_lb0;
                r_win[2][2] <= in_pixel;
                r_cx        <= r_col - 1'b1;
                r_cy        <= r_row - 1'b1;
            end

            // While stalled the pending window and its valid are held, and the
            // Sobel stage is fed the window it already holds so its result repeats.
            if (!w_stall) begin
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        r_win_prev[i][j] <= r_win[i][j];
                    end
                end
                r_cx_prev   <= r_cx;
                r_cy_prev   <= r_cy;
                r_win_valid <= w_accept && (r_col >= TWO) && (r_row >= TWO);
            end

            r_out_x     <= w_stall ? r_cx_prev : r_cx;
            r_out_y     <= w_stall ? r_cy_prev : r_cy;
            r_out_valid <= w_stall ? 1'b1 : r_win_valid;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_sob_in[i][j] = w_stall ? r_win_prev[i][j] : r_win[i][j];
            end
        end
    end

    assign win_x00 = w_sob_in[0][0];
    assign win_x01 = w_sob_in[0][1];
    assign win_x02 = w_sob_in[0][2];
    assign win_x10 = w_sob_in[1][0];
    assign win_x11 = w_sob_in[1][1];
    assign win_x12 = w_sob_in[1][2];
    assign win_x20 = w_sob_in[2][0];
    assign win_x21 = w_sob_in[2][1];
    assign win_x22 = w_sob_in[2][2];

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_ix     = sob_ix;
    assign out_iy     = sob_iy;
    assign out_x      = r_out_x;
    assign out_y      = r_out_y;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;

`ifdef SOBEL_MAG_EN
    assign out_mag = r_out_valid ? (grad_abs(sob_ix) + grad_abs(sob_iy)) : '0;
`endif

endmodule
